// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg : opcodes, ALU select encodings and shared types for the issue   |
// | stage.                                              Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] c_OUT_ARITH = 2'b00;
   localparam logic [1:0] c_OUT_COMP  = 2'b01;
   localparam logic [1:0] c_OUT_LOGIC = 2'b10;
   localparam logic [1:0] c_OUT_SHIFT = 2'b11;

   localparam logic [1:0] c_SHIFT_SLL = 2'b00;
   localparam logic [1:0] c_SHIFT_SRL = 2'b10;
   localparam logic [1:0] c_SHIFT_SRA = 2'b11;

   localparam logic [1:0] c_LOGIC_XOR = 2'b00;
   localparam logic [1:0] c_LOGIC_OR  = 2'b01;
   localparam logic [1:0] c_LOGIC_AND = 2'b10;

   typedef struct packed {
      logic       sel_a;
      logic       sel_comp;
      logic [1:0] sel_s;
      logic [1:0] sel_l;
      logic [1:0] sel_alu_out;
   } alu_ctrl_t;

   localparam alu_ctrl_t c_CTRL_ADD = '0;

   typedef enum logic [1:0] {
      SRCA_RS1  = 2'b00,
      SRCA_PC   = 2'b01,
      SRCA_ZERO = 2'b10
   } srca_sel_e;

   typedef enum logic [0:0] {
      SRCB_RS2 = 1'b0,
      SRCB_IMM = 1'b1
   } srcb_sel_e;

   // x0 never forwards; the younger EX/MEM result wins over MEM/WB
   function automatic logic [31:0] fwd_pick(
      input logic [4:0]  rs,
      input logic [31:0] rf_data,
      input logic        mem_we,
      input logic [4:0]  mem_rd,
      input logic [31:0] mem_data,
      input logic        wb_we,
      input logic [4:0]  wb_rd,
      input logic [31:0] wb_data
   );
      if (rs != 5'd0 && mem_we && mem_rd == rs) return mem_data;
      if (rs != 5'd0 && wb_we && wb_rd == rs) return wb_data;
      return rf_data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// +--------------------------------------------------------------------------+
// | alu_op_decode : combinational RV32I decode into ALU selects, immediate,  |
// | operand selects, rd write enable and illegal flag.  Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_op_decode
   import alu_pkg::*;
#(
   parameter int ILLEGAL_AS_NOP = 1
) (
   input  logic [31:0] i_instr,
   output alu_ctrl_t   o_ctrl,
   output logic [31:0] o_imm,
   output srca_sel_e   o_srca_sel,
   output srcb_sel_e   o_srcb_sel,
   output logic        o_rd_we,
   output logic        o_illegal
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i, w_imm_s, w_imm_u, w_imm_j;
   logic        w_class_we;

   assign w_opc   = i_instr[6:0];
   assign w_f3    = i_instr[14:12];
   assign w_f7    = i_instr[31:25];
   assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_u = {i_instr[31:12], 12'b0};
   assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      o_ctrl     = c_CTRL_ADD;
      o_imm      = '0;
      o_srca_sel = SRCA_RS1;
      o_srcb_sel = SRCB_RS2;
      w_class_we = 1'b0;
      o_illegal  = 1'b0;
      case (w_opc)
         c_OPC_OP, c_OPC_OP_IMM: begin
            w_class_we = 1'b1;
            if (w_opc == c_OPC_OP) begin
               o_illegal = !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
            end else begin
               o_srcb_sel = SRCB_IMM;
               o_imm      = w_imm_i;
            end
            case (w_f3)
               3'b000: o_ctrl.sel_a = (w_opc == c_OPC_OP) && i_instr[30];
               3'b010: begin
                  o_ctrl.sel_a       = 1'b1;
                  o_ctrl.sel_comp    = 1'b1;
                  o_ctrl.sel_alu_out = c_OUT_COMP;
               end
               3'b011: begin
                  o_ctrl.sel_a       = 1'b1;
                  o_ctrl.sel_alu_out = c_OUT_COMP;
               end
               3'b100: begin
                  o_ctrl.sel_l       = c_LOGIC_XOR;
                  o_ctrl.sel_alu_out = c_OUT_LOGIC;
               end
               3'b110: begin
                  o_ctrl.sel_l       = c_LOGIC_OR;
                  o_ctrl.sel_alu_out = c_OUT_LOGIC;
               end
               3'b111: begin
                  o_ctrl.sel_l       = c_LOGIC_AND;
                  o_ctrl.sel_alu_out = c_OUT_LOGIC;
               end
               default: begin
                  o_ctrl.sel_s       = (w_f3 == 3'b001) ? c_SHIFT_SLL :
                                       (i_instr[30] ? c_SHIFT_SRA : c_SHIFT_SRL);
                  o_ctrl.sel_alu_out = c_OUT_SHIFT;
                  if (w_opc == c_OPC_OP_IMM) begin
                     o_imm     = {27'b0, i_instr[24:20]};
                     o_illegal = i_instr[25];
                  end
               end
            endcase
         end
         c_OPC_LUI: begin
            o_srca_sel = SRCA_ZERO;
            o_srcb_sel = SRCB_IMM;
            o_imm      = w_imm_u;
            w_class_we = 1'b1;
         end
         c_OPC_AUIPC, c_OPC_JAL: begin
            o_srca_sel = SRCA_PC;
            o_srcb_sel = SRCB_IMM;
            o_imm      = (w_opc == c_OPC_JAL) ? w_imm_j : w_imm_u;
            w_class_we = 1'b1;
         end
         c_OPC_JALR, c_OPC_LOAD: begin
            o_srcb_sel = SRCB_IMM;
            o_imm      = w_imm_i;
            w_class_we = 1'b1;
         end
         c_OPC_STORE: begin
            o_srcb_sel = SRCB_IMM;
            o_imm      = w_imm_s;
         end
         c_OPC_BRANCH: begin
            o_ctrl.sel_a = 1'b1;
            if (w_f3[2]) begin
               o_ctrl.sel_comp    = !w_f3[1];
               o_ctrl.sel_alu_out = c_OUT_COMP;
            end
         end
         default: o_illegal = 1'b1;
      endcase
      if (o_illegal) o_ctrl = c_CTRL_ADD;
   end

   assign o_rd_we = w_class_we && !(o_illegal && ILLEGAL_AS_NOP != 0) && (i_instr[11:7] != 5'd0);

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// +--------------------------------------------------------------------------+
// | alu_issue_stage : ID/EX valid/ready register feeding the ALU, with flush |
// | and optional operand forwarding (ALU_ISSUE_FWD_EN).  Revision: 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int ILLEGAL_AS_NOP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic            fwd_mem_we,
   input  logic [4:0]      fwd_mem_rd,
   input  logic [XLEN-1:0] fwd_mem_data,
   input  logic            fwd_wb_we,
   input  logic [4:0]      fwd_wb_rd,
   input  logic [XLEN-1:0] fwd_wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_srcA,
   output logic [XLEN-1:0] out_srcB,
   output logic            out_sel_a,
   output logic            out_sel_comp,
   output logic [1:0]      out_sel_s,
   output logic [1:0]      out_sel_l,
   output logic [1:0]      out_sel_alu_out,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [4:0]      out_rd,
   output logic            out_rd_we,
   output logic            out_illegal
);

   alu_ctrl_t       w_ctrl;
   logic [31:0]     w_imm;
   srca_sel_e       w_srca_sel;
   srcb_sel_e       w_srcb_sel;
   logic            w_rd_we, w_illegal, w_accept;
   logic [XLEN-1:0] w_rs1, w_rs2, w_srca, w_srcb;

   logic            r_valid;
   logic [XLEN-1:0] r_srca, r_srcb, r_rs2;
   alu_ctrl_t       r_ctrl;
   logic [4:0]      r_rd;
   logic            r_rd_we, r_illegal;

   alu_op_decode #(.ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)) u_decode (
      .i_instr    (in_instr),
      .o_ctrl     (w_ctrl),
      .o_imm      (w_imm),
      .o_srca_sel (w_srca_sel),
      .o_srcb_sel (w_srcb_sel),
      .o_rd_we    (w_rd_we),
      .o_illegal  (w_illegal)
   );

`ifdef ALU_ISSUE_FWD_EN
   assign w_rs1 = fwd_pick(in_instr[19:15], in_rs1_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
   assign w_rs2 = fwd_pick(in_instr[24:20], in_rs2_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data};
   assign w_rs1 = in_rs1_data;
   assign w_rs2 = in_rs2_data;
`endif

   always_comb begin
      case (w_srca_sel)
         SRCA_PC:   w_srca = in_pc;
         SRCA_ZERO: w_srca = '0;
         default:   w_srca = w_rs1;
      endcase
      w_srcb = (w_srcb_sel == SRCB_IMM) ? w_imm : w_rs2;
   end

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_srca    <= '0;
         r_srcb    <= '0;
         r_rs2     <= '0;
         r_ctrl    <= c_CTRL_ADD;
         r_rd      <= '0;
         r_rd_we   <= 1'b0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_srca    <= w_srca;
         r_srcb    <= w_srcb;
         r_rs2     <= w_rs2;
         r_ctrl    <= w_ctrl;
         r_rd      <= in_instr[11:7];
         r_rd_we   <= w_rd_we;
         r_illegal <= w_illegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid       = r_valid;
   assign out_srcA        = r_srca;
   assign out_srcB        = r_srcb;
   assign out_rs2_data    = r_rs2;
   assign out_sel_a       = r_ctrl.sel_a;
   assign out_sel_comp    = r_ctrl.sel_comp;
   assign out_sel_s       = r_ctrl.sel_s;
   assign out_sel_l       = r_ctrl.sel_l;
   assign out_sel_alu_out = r_ctrl.sel_alu_out;
   assign out_rd          = r_rd;
   assign out_rd_we       = r_rd_we;
   assign out_illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// +--------------------------------------------------------------------------+
// | tb_alu_issue_stage : scoreboard bench for alu_issue_stage (directed plus |
// | random traffic; honours ALU_ISSUE_FWD_EN).           Revision: 1.0       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [31:0] in_instr = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
   logic        fwd_mem_we = 1'b0, fwd_wb_we = 1'b0;
   logic [4:0]  fwd_mem_rd = '0, fwd_wb_rd = '0;
   logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;
   logic [31:0] out_srcA, out_srcB, out_rs2_data;
   logic        out_sel_a, out_sel_comp, out_rd_we, out_illegal;
   logic [1:0]  out_sel_s, out_sel_l, out_sel_alu_out;
   logic [4:0]  out_rd;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32), .ILLEGAL_AS_NOP(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_srcA(out_srcA), .out_srcB(out_srcB),
      .out_sel_a(out_sel_a), .out_sel_comp(out_sel_comp), .out_sel_s(out_sel_s),
      .out_sel_l(out_sel_l), .out_sel_alu_out(out_sel_alu_out), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
   );

   typedef struct {
      logic        v, rdy, fl, rs;
      logic [31:0] instr, pc, r1, r2;
      logic        mwe, wwe;
      logic [4:0]  mrd, wrd;
      logic [31:0] mdata, wdata;
   } stim_t;

   typedef struct {
      logic [31:0] srca, srcb, rs2;
      logic        sel_a, comp, we, ill;
      logic [1:0]  s, l, o;
      logic [4:0]  rd;
   } exp_t;

   typedef enum {K_ADD, K_SUB, K_SLT, K_SLTU, K_XOR, K_OR, K_AND, K_SLL, K_SRL, K_SRA, K_ILL} kind_e;

   exp_t q[$];
   int   checks = 0, passes = 0;
   logic m_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] d, input stim_t s);
      if (r == 5'd0) return d;
`ifdef ALU_ISSUE_FWD_EN
      if (s.mwe && s.mrd == r) return s.mdata;
      if (s.wwe && s.wrd == r) return s.wdata;
`else
      if (s.v === 1'bx) return 32'hx;
`endif
      return d;
   endfunction

   // Instruction semantics: pick the operation, its operands and whether it writes rd
   function automatic exp_t ref_model(input stim_t s);
      exp_t        e;
      kind_e       k;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a, b, rs1v, rs2v;
      int          ii, is, ij;
      logic        writes;
      op = s.instr[6:0]; f3 = s.instr[14:12]; f7 = s.instr[31:25];
      rs1v = fwd_val(s.instr[19:15], s.r1, s);
      rs2v = fwd_val(s.instr[24:20], s.r2, s);
      ii = $signed(s.instr[31:20]);
      is = $signed({s.instr[31:25], s.instr[11:7]});
      ij = $signed({s.instr[31], s.instr[19:12], s.instr[20], s.instr[30:21], 1'b0});
      a = rs1v; b = rs2v; k = K_ADD; writes = 1'b1;
      case (op)
         7'h33, 7'h13: begin
            if (op == 7'h13) b = ii;
            case (f3)
               3'd0: k = (op == 7'h33 && f7 == 7'h20) ? K_SUB : K_ADD;
               3'd1: k = K_SLL;
               3'd2: k = K_SLT;
               3'd3: k = K_SLTU;
               3'd4: k = K_XOR;
               3'd5: k = s.instr[30] ? K_SRA : K_SRL;
               3'd6: k = K_OR;
               default: k = K_AND;
            endcase
            if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
               b = s.instr[24:20];
               if (s.instr[25]) k = K_ILL;
            end
            if (op == 7'h33 && f7 != 7'h00 && f7 != 7'h20) k = K_ILL;
         end
         7'h37: begin a = 0; b = s.instr & 32'hFFFFF000; end
         7'h17: begin a = s.pc; b = s.instr & 32'hFFFFF000; end
         7'h6F: begin a = s.pc; b = ij; end
         7'h67, 7'h03: b = ii;
         7'h23: begin b = is; writes = 1'b0; end
         7'h63: begin
            writes = 1'b0;
            k = (f3 == 3'd4 || f3 == 3'd5) ? K_SLT : (f3 >= 3'd6) ? K_SLTU : K_SUB;
         end
         default: begin k = K_ILL; writes = 1'b0; end
      endcase
      e.srca = a; e.srcb = b; e.rs2 = rs2v; e.rd = s.instr[11:7];
      e.ill = (k == K_ILL);
      e.we = writes && !e.ill && (s.instr[11:7] != 0);
      e.sel_a = (k == K_SUB || k == K_SLT || k == K_SLTU);
      e.comp  = (k == K_SLT);
      e.s = (k == K_SRL) ? 2'b10 : (k == K_SRA) ? 2'b11 : 2'b00;
      e.l = (k == K_OR) ? 2'b01 : (k == K_AND) ? 2'b10 : 2'b00;
      e.o = (k == K_SLT || k == K_SLTU) ? 2'b01 :
            (k == K_XOR || k == K_OR || k == K_AND) ? 2'b10 :
            (k == K_SLL || k == K_SRL || k == K_SRA) ? 2'b11 : 2'b00;
      return e;
   endfunction

   function automatic stim_t idle(input logic rdy);
      stim_t s;
      s = '{default: '0};
      s.rdy = rdy;
      return s;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] x;
      logic [6:0]  ops[9];
      int          k;
      ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
      x = $urandom;
      k = $urandom_range(0, 10);
      if (k < 9) x[6:0] = ops[k];
      if (x[6:0] == 7'h33 && $urandom_range(0, 3) != 0) x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if (x[6:0] == 7'h13 && x[13:12] == 2'b01) begin
         x[31:26] = ($urandom_range(0, 1) != 0) ? 6'b010000 : 6'b000000;
         x[25]    = ($urandom_range(0, 3) == 0);
      end
      if (x[6:0] == 7'h63 && x[14:13] == 2'b01) x[14] = 1'b1;
      return x;
   endfunction

   // One clock of stimulus; the occupancy model decides acceptance and feeds the scoreboard
   task automatic cycle(input stim_t s);
      @(negedge clk);
      in_valid = s.v; out_ready = s.rdy; flush = s.fl; rst = s.rs;
      in_instr = s.instr; in_pc = s.pc; in_rs1_data = s.r1; in_rs2_data = s.r2;
      fwd_mem_we = s.mwe; fwd_mem_rd = s.mrd; fwd_mem_data = s.mdata;
      fwd_wb_we = s.wwe; fwd_wb_rd = s.wrd; fwd_wb_data = s.wdata;
      #1;
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, !m_valid || s.rdy);
      if (s.rs || s.fl) m_valid = 1'b0;
      else if (s.v && (!m_valid || s.rdy)) begin
         q.push_back(ref_model(s));
         m_valid = 1'b1;
      end else if (s.rdy) m_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_issue: got out_valid=1 expected no pending instr");
            end else begin
               e = q[0];
               if (!e.ill) begin
                  check("srcA", out_srcA, e.srca);
                  check("srcB", out_srcB, e.srcb);
               end
               check("rs2_data", out_rs2_data, e.rs2);
               check("sel_a", out_sel_a, e.sel_a);
               check("sel_comp", out_sel_comp, e.comp);
               check("sel_s", out_sel_s, e.s);
               check("sel_l", out_sel_l, e.l);
               check("sel_alu_out", out_sel_alu_out, e.o);
               check("rd", out_rd, e.rd);
               check("rd_we", out_rd_we, e.we);
               check("illegal", out_illegal, e.ill);
               if (out_ready || flush || rst) void'(q.pop_front());
            end
         end
      end
   end

   initial begin : driver
      stim_t s;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      cycle(idle(1'b0));
      check("rst_srcA", out_srcA, 0);
      check("rst_sel_alu_out", out_sel_alu_out, 0);
      check("rst_rd_we", out_rd_we, 0);

      // ADDI x5,x1,-1 with rs1=10
      s = idle(1'b1); s.v = 1; s.instr = 32'hFFF08293; s.r1 = 10; s.r2 = 32'h55;
      cycle(s);
      cycle(idle(1'b0));
      check("addi_srcA", out_srcA, 10);
      check("addi_srcB", out_srcB, 32'hFFFFFFFF);
      check("addi_out", {out_sel_a, out_sel_alu_out}, 3'b000);
      check("addi_rd", out_rd, 5);

      // SRAI x2,x3,4 then SRLI with bit25 set
      s = idle(1'b1); s.v = 1; s.instr = {7'b0100000, 5'd4, 5'd3, 3'b101, 5'd2, 7'h13};
      cycle(s);
      cycle(idle(1'b0));
      check("srai_srcB", out_srcB, 4);
      check("srai_sel", {out_sel_s, out_sel_alu_out}, 4'b1111);
      s.instr = {7'b0000001, 5'd4, 5'd3, 3'b101, 5'd2, 7'h13};
      cycle(s);
      cycle(idle(1'b0));
      check("srli_bad_ill", {out_illegal, out_rd_we}, 2'b10);

      // BLTU rs1=1 rs2=2
      s = idle(1'b1); s.v = 1; s.instr = {7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'h63}; s.r1 = 1; s.r2 = 2;
      cycle(s);
      cycle(idle(1'b0));
      check("bltu_sel", {out_sel_a, out_sel_comp, out_sel_alu_out, out_rd_we}, 5'b10010);

      // Stall three cycles with a pending instr, then release
      cycle(idle(1'b1));
      s = idle(1'b1); s.v = 1; s.instr = 32'h00310233; s.r1 = 7; s.r2 = 9;
      cycle(s);
      s.rdy = 0; s.instr = 32'h40310233; s.r1 = 20;
      repeat (3) cycle(s);
      s.rdy = 1;
      cycle(s);
      cycle(idle(1'b0));
      check("stall_next_sub", out_sel_a, 1);

      // Flush with incoming instr and a held one
      s = idle(1'b0); s.v = 1; s.fl = 1; s.instr = 32'h00A00093;
      cycle(s);
      cycle(idle(1'b0));

      // Reset during a stall
      s = idle(1'b1); s.v = 1; s.instr = 32'h0040C113; s.r1 = 32'h1234;
      cycle(s);
      s.rdy = 0;
      cycle(s);
      s.rs = 1;
      cycle(s);
      cycle(idle(1'b0));
      check("rststall_xor_cleared", {out_sel_l, out_sel_alu_out, out_srcA[15:0]}, 20'h0);

`ifdef ALU_ISSUE_FWD_EN
      s = idle(1'b1); s.v = 1; s.instr = {12'h0, 5'd3, 3'b000, 5'd4, 7'h13}; s.r1 = 32'h11;
      s.mwe = 1; s.mrd = 3; s.mdata = 32'hAA; s.wwe = 1; s.wrd = 3; s.wdata = 32'hBB;
      cycle(s);
      cycle(idle(1'b0));
      check("fwd_mem_wins", out_srcA, 32'hAA);
      s.instr = {12'h0, 5'd0, 3'b000, 5'd4, 7'h13}; s.r1 = 32'h22; s.mrd = 0; s.wrd = 0;
      cycle(s);
      cycle(idle(1'b0));
      check("fwd_x0_regfile", out_srcA, 32'h22);
`endif

      for (int n = 0; n < 3000; n++) begin
         s.v = ($urandom_range(0, 3) != 0);
         s.rdy = ($urandom_range(0, 3) != 0);
         s.fl = ($urandom_range(0, 19) == 0);
         s.rs = ($urandom_range(0, 49) == 0);
         s.instr = rand_instr(); s.pc = $urandom; s.r1 = $urandom; s.r2 = $urandom;
         s.mwe = $urandom_range(0, 1); s.wwe = $urandom_range(0, 1);
         s.mrd = ($urandom_range(0, 1) != 0) ? s.instr[19:15] : 5'($urandom);
         s.wrd = ($urandom_range(0, 1) != 0) ? s.instr[24:20] : s.instr[19:15];
         s.mdata = $urandom; s.wdata = $urandom;
         cycle(s);
      end

      repeat (4) cycle(idle(1'b1));
      check("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
